// File: rtl/buf_alloc_pkg.sv
// Shared constants, slot address type and the lowest-free-slot encoder
// for the multi-channel buffer allocator.
package buf_alloc_pkg;

    localparam int unsigned NBUF_DEF  = 16;
    localparam int unsigned NCH_DEF   = 4;
    localparam int unsigned AFULL_DEF = 2;
    localparam int unsigned AW_DEF    = $clog2(NBUF_DEF);
    localparam int unsigned CW_DEF    = AW_DEF + 1;

    // Largest pool the encoder below can search; callers pad unused bits with 1s.
    localparam int unsigned MAX_NBUF = 256;
    localparam int unsigned MAX_AW   = $clog2(MAX_NBUF);

    typedef logic [AW_DEF-1:0] slot_addr_t;
    typedef logic [CW_DEF-1:0] slot_count_t;

    // Lowest index holding a 0; returns 0 when every bit is set.
    function automatic logic [MAX_AW-1:0] first_zero(input logic [MAX_NBUF-1:0] busy);
        logic [MAX_AW-1:0] idx;
        idx = '0;
        for (int unsigned i = MAX_NBUF; i > 0; i--) begin
            if (!busy[i-1]) idx = MAX_AW'(i - 1);
        end
        return idx;
    endfunction

endpackage

// File: rtl/buf_alloc_rr_arb.sv
// Round-robin arbiter: picks the first requester at or above rr_ptr (mod NCH)
// and moves the pointer past the winner whenever a grant is taken.
module buf_alloc_rr_arb #(
    parameter int unsigned NCH = 4,
    parameter int unsigned WW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [NCH-1:0] req,
    input  logic           enable,
    input  logic           advance,
    output logic [NCH-1:0] gnt,
    output logic [WW-1:0]  win
);

    logic [WW-1:0] rr_ptr;
    logic          found;
    int unsigned   idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = (32'(rr_ptr) + k) % NCH;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = WW'(idx);
            end
        end
        gnt = '0;
        if (enable && found) gnt[win] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (win == WW'(NCH - 1)) ? '0 : win + WW'(1);
        end
    end

endmodule

// File: rtl/buf_alloc_mc.sv
// Multi-channel buffer-slot allocator: registered requests, one round-robin
// grant per cycle to the lowest free slot, one free per cycle, sticky double-free flag.
module buf_alloc_mc
    import buf_alloc_pkg::*;
#(
    parameter int unsigned NBUF  = NBUF_DEF,
    parameter int unsigned NCH   = NCH_DEF,
    parameter int unsigned AW    = $clog2(NBUF),
    parameter int unsigned AFULL = AFULL_DEF
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [NCH-1:0] alloc_req,
    input  logic           free_vld,
    input  logic [AW-1:0]  free_addr,
    output logic [NCH-1:0] alloc_gnt,
    output logic [NCH-1:0] alloc_nack,
    output logic [AW-1:0]  alloc_addr,
    output logic [AW:0]    count,
    output logic           full,
    output logic           almost_full,
    output logic           empty,
    output logic           free_err
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]      req_q;
    logic                fvld_q;
    logic [AW-1:0]       faddr_q;
    logic [NBUF-1:0]     busy;
    logic [NBUF-1:0]     busy_next;
    logic [MAX_NBUF-1:0] busy_ext;
    logic                gnt_any;
    logic                valid_free;
    logic [WW-1:0]       win;

    buf_alloc_rr_arb #(
        .NCH (NCH),
        .WW  (WW)
    ) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req_q),
        .enable  (~full),
        .advance (gnt_any),
        .gnt     (alloc_gnt),
        .win     (win)
    );

    assign gnt_any     = |alloc_gnt;
    assign full        = (count == CW'(NBUF));
    assign empty       = (count == '0);
    assign almost_full = ((32'(NBUF) - 32'(count)) <= AFULL);
    assign alloc_nack  = full ? req_q : '0;
    assign valid_free  = fvld_q && (32'(faddr_q) < NBUF) && busy[faddr_q];

    // Slots beyond NBUF read as busy so the encoder never offers them.
    always_comb begin
        busy_ext             = '1;
        busy_ext[NBUF-1:0]   = busy;
        alloc_addr           = AW'(first_zero(busy_ext));
    end

    // alloc_addr is taken from pre-update busy, so set and clear never hit the same slot.
    always_comb begin
        busy_next = busy;
        if (valid_free) busy_next[faddr_q] = 1'b0;
        if (gnt_any)    busy_next[alloc_addr] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q    <= '0;
            fvld_q   <= 1'b0;
            faddr_q  <= '0;
            busy     <= '0;
            count    <= '0;
            free_err <= 1'b0;
        end else begin
            req_q   <= alloc_req;
            fvld_q  <= free_vld;
            faddr_q <= free_addr;
            busy    <= busy_next;
            count   <= count + CW'(gnt_any) - CW'(valid_free);
            if (fvld_q && !valid_free) free_err <= 1'b1;
        end
    end

    a_count: assert property (@(posedge clock) disable iff (!reset_n)
        (32'(count) == $countones(busy)) && (32'(count) <= NBUF));
    a_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(alloc_gnt));
    a_win: assert property (@(posedge clock) disable iff (!reset_n)
        !gnt_any || alloc_gnt[win]);
    a_gnt_nack: assert property (@(posedge clock) disable iff (!reset_n)
        (alloc_gnt & alloc_nack) == '0);
    a_sticky: assert property (@(posedge clock) disable iff (!reset_n)
        free_err |=> free_err);

endmodule
